// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - capture write queue and readout arbiter sharing one async SRAM
// Optional SRAM_ARB_DROP_CNT_EN adds a saturating dropped-pixel counter output (drop_cnt).
module sram_arbiter #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_WORDS = 19200
) (
    input  logic        pclk,
    input  logic        res,
    input  logic        vsync,
    input  logic        pix_valid,
    input  logic [11:0] pix_data,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        rd_gnt,
    output logic        rd_valid,
    output logic [11:0] rd_data,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        WEb,
    output logic        OEb,
    output logic        BLEb,
    output logic        BHEb,
    output logic [15:0] wr_addr,
    output logic        fifo_full,
    output logic        frame_done
`ifdef SRAM_ARB_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        RD_SETUP,
        RD_SAMPLE
    } state_t;

    state_t          state, state_nxt;
    logic [11:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, head_nxt;
    logic [CW-1:0]   count, arb_count;
    logic            vsync_q, vs_edge;
    logic            abandon;
    logic            last_wr;
    logic [15:0]     wr_lat_addr, rd_lat_addr, wr_addr_nxt;
    logic [11:0]     wr_lat_data;
    logic            pop, push_ok, wr_pend, urgent, grant_wr, grant_rd;
    logic            unused_dq;

    assign unused_dq = ^sram_dq_i[15:12];

    assign vs_edge   = vsync & ~vsync_q;
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign push_ok   = pix_valid && !fifo_full;
    // A write abandoned by a frame sync already had its entry flushed, so it must not pop.
    assign pop       = (state == WR_STROBE) && !abandon && !vs_edge;
    assign arb_count = count - CW'(pop);
    assign head_nxt  = rd_ptr + PW'(pop);
    assign wr_pend   = (arb_count != '0) && !vs_edge;
    assign urgent    = (arb_count >= CW'(FIFO_DEPTH - 1));

    always_comb begin
        wr_addr_nxt = wr_addr;
        if (vs_edge) begin
            wr_addr_nxt = '0;
        end else if (pop) begin
            wr_addr_nxt = (wr_addr == 16'(FRAME_WORDS - 1)) ? 16'd0 : wr_addr + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            IDLE, WR_STROBE, RD_SAMPLE: begin
                if (wr_pend && (urgent || !rd_req || !last_wr)) begin
                    grant_wr = 1'b1;
                end else if (rd_req) begin
                    grant_rd = 1'b1;
                end
                state_nxt = grant_wr ? WR_SETUP : (grant_rd ? RD_SETUP : IDLE);
            end
            WR_SETUP: state_nxt = WR_STROBE;
            RD_SETUP: state_nxt = RD_SAMPLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        WEb        = 1'b1;
        OEb        = 1'b1;
        BLEb       = 1'b1;
        BHEb       = 1'b1;
        rd_gnt     = 1'b0;
        case (state)
            WR_SETUP, WR_STROBE: begin
                sram_addr  = wr_lat_addr;
                sram_dq_o  = {4'h0, wr_lat_data};
                sram_dq_oe = 1'b1;
                WEb        = (state != WR_STROBE);
                BLEb       = 1'b0;
                BHEb       = 1'b0;
            end
            RD_SETUP, RD_SAMPLE: begin
                sram_addr = rd_lat_addr;
                OEb       = 1'b0;
                BLEb      = 1'b0;
                BHEb      = 1'b0;
                rd_gnt    = (state == RD_SETUP);
            end
            default: ;
        endcase
    end

    // On a frame sync the pixel arriving in the same cycle becomes slot 0 of the new frame.
    always_ff @(posedge pclk) begin
        if (!res && (vs_edge ? pix_valid : push_ok)) begin
            mem[vs_edge ? '0 : wr_ptr] <= pix_data;
        end
    end

    always_ff @(posedge pclk) begin
        vsync_q <= vsync;
        if (res) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            wr_addr     <= '0;
            last_wr     <= 1'b0;
            abandon     <= 1'b0;
            wr_lat_addr <= '0;
            wr_lat_data <= '0;
            rd_lat_addr <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            frame_done <= pop && (wr_addr == 16'(FRAME_WORDS - 1));
            rd_valid   <= (state == RD_SAMPLE);
            if (state == RD_SAMPLE) begin
                rd_data <= sram_dq_i[11:0];
            end

            if (vs_edge) begin
                rd_ptr <= '0;
                wr_ptr <= PW'(pix_valid);
                count  <= CW'(pix_valid);
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push_ok) - CW'(pop);
            end

            if (grant_wr) begin
                wr_lat_addr <= wr_addr_nxt;
                wr_lat_data <= mem[head_nxt];
                last_wr     <= 1'b1;
                abandon     <= 1'b0;
            end else if (state == WR_SETUP && vs_edge) begin
                abandon <= 1'b1;
            end
            if (grant_rd) begin
                rd_lat_addr <= rd_addr;
                last_wr     <= 1'b0;
            end
        end
    end

`ifdef SRAM_ARB_DROP_CNT_EN
    always_ff @(posedge pclk) begin
        if (res || vs_edge) begin
            drop_cnt <= '0;
        end else if (pix_valid && fifo_full && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed vector bench for sram_arbiter
module tb_sram_arbiter;

    logic        pclk = 1'b0;
    logic        res, vsync, pix_valid, rd_req;
    logic [11:0] pix_data;
    logic [15:0] rd_addr, sram_dq_i;
    logic        rd_gnt, rd_valid, sram_dq_oe, WEb, OEb, BLEb, BHEb, fifo_full, frame_done;
    logic [11:0] rd_data;
    logic [15:0] sram_addr, sram_dq_o, wr_addr;
`ifdef SRAM_ARB_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    sram_arbiter dut (
        .pclk(pclk), .res(res), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .WEb(WEb), .OEb(OEb),
        .BLEb(BLEb), .BHEb(BHEb), .wr_addr(wr_addr), .fifo_full(fifo_full),
        .frame_done(frame_done)
`ifdef SRAM_ARB_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    localparam logic [4:0] S_IDL = 5'b01111;  // {dq_oe, WEb, OEb, BLEb, BHEb}
    localparam logic [4:0] S_SET = 5'b11100;
    localparam logic [4:0] S_STB = 5'b10100;
    localparam logic [4:0] S_RD  = 5'b01000;

    typedef struct {
        logic        pv;
        logic [11:0] pd;
        logic        rq;
        logic [15:0] ra;
        logic [15:0] dqi;
        logic [15:0] e_addr;
        logic [15:0] e_dq;
        logic [4:0]  e_strb;
        logic        e_gnt;
        logic        e_vld;
        logic [11:0] e_rdata;
        logic [15:0] e_wa;
        logic        e_full;
        logic        e_fd;
    } vec_t;

    vec_t tbl[12];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic pv, logic [11:0] pd, logic rq, logic [15:0] ra,
                                logic [15:0] dqi, logic [15:0] addr, logic [15:0] dq,
                                logic [4:0] strb, logic gnt, logic vld, logic [11:0] rdata,
                                logic [15:0] wa, logic full, logic fd);
        vec_t v;
        v.pv = pv; v.pd = pd; v.rq = rq; v.ra = ra; v.dqi = dqi;
        v.e_addr = addr; v.e_dq = dq; v.e_strb = strb; v.e_gnt = gnt; v.e_vld = vld;
        v.e_rdata = rdata; v.e_wa = wa; v.e_full = full; v.e_fd = fd;
        return v;
    endfunction

    function automatic logic [68:0] obs();
        return {sram_addr, sram_dq_o, sram_dq_oe, WEb, OEb, BLEb, BHEb, rd_gnt, rd_valid,
                rd_data, wr_addr, fifo_full, frame_done};
    endfunction

    function automatic logic [68:0] expv(vec_t v);
        return {v.e_addr, v.e_dq, v.e_strb, v.e_gnt, v.e_vld, v.e_rdata, v.e_wa, v.e_full, v.e_fd};
    endfunction

    task automatic cmp(input string name, input logic [68:0] got, input logic [68:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic do_reset();
        res = 1'b1; pix_valid = 1'b0; rd_req = 1'b0; vsync = 1'b0;
        tick();
        tick();
        res = 1'b0;
    endtask

    logic [68:0] reset_obs;
    logic [11:0] wlog[$];
    byte         glog[$];
    string       exp_g;
    logic [11:0] exp_w[5];
    int          full_seen, fd_seen, wr_seen, vld_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pix_data = '0; rd_addr = '0; sram_dq_i = 16'hABCD;
        reset_obs = {16'h0, 16'h0, S_IDL, 1'b0, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0};

        tbl[0]  = mk(1, 12'h123, 0, 16'h0,  16'hABCD, 16'h0,  16'h0,    S_IDL, 0, 0, 12'h0,   16'd0, 0, 0);
        tbl[1]  = mk(1, 12'h456, 0, 16'h0,  16'hABCD, 16'h0,  16'h0123, S_SET, 0, 0, 12'h0,   16'd0, 0, 0);
        tbl[2]  = mk(1, 12'h789, 0, 16'h0,  16'hABCD, 16'h0,  16'h0123, S_STB, 0, 0, 12'h0,   16'd0, 0, 0);
        tbl[3]  = mk(0, 12'h0,   0, 16'h0,  16'hABCD, 16'h1,  16'h0456, S_SET, 0, 0, 12'h0,   16'd1, 0, 0);
        tbl[4]  = mk(0, 12'h0,   0, 16'h0,  16'hABCD, 16'h1,  16'h0456, S_STB, 0, 0, 12'h0,   16'd1, 0, 0);
        tbl[5]  = mk(0, 12'h0,   0, 16'h0,  16'hABCD, 16'h2,  16'h0789, S_SET, 0, 0, 12'h0,   16'd2, 0, 0);
        tbl[6]  = mk(0, 12'h0,   0, 16'h0,  16'hABCD, 16'h2,  16'h0789, S_STB, 0, 0, 12'h0,   16'd2, 0, 0);
        tbl[7]  = mk(0, 12'h0,   0, 16'h0,  16'hABCD, 16'h0,  16'h0,    S_IDL, 0, 0, 12'h0,   16'd3, 0, 0);
        tbl[8]  = mk(0, 12'h0,   1, 16'h10, 16'hABCD, 16'h10, 16'h0,    S_RD,  1, 0, 12'h0,   16'd3, 0, 0);
        tbl[9]  = mk(0, 12'h0,   0, 16'h10, 16'hABCD, 16'h10, 16'h0,    S_RD,  0, 0, 12'h0,   16'd3, 0, 0);
        tbl[10] = mk(0, 12'h0,   0, 16'h0,  16'hABCD, 16'h0,  16'h0,    S_IDL, 0, 1, 12'hBCD, 16'd3, 0, 0);
        tbl[11] = mk(0, 12'h0,   0, 16'h0,  16'h1111, 16'h0,  16'h0,    S_IDL, 0, 0, 12'hBCD, 16'd3, 0, 0);

        // Reset values, then capture writes and a single read from IDLE
        do_reset();
        cmp("reset_state", obs(), reset_obs);
`ifdef SRAM_ARB_DROP_CNT_EN
        cmp("reset_drop_cnt", 69'(drop_cnt), 69'd0);
`endif
        for (int i = 0; i < 12; i++) begin
            pix_valid = tbl[i].pv; pix_data = tbl[i].pd; rd_req = tbl[i].rq;
            rd_addr = tbl[i].ra; sram_dq_i = tbl[i].dqi;
            tick();
            cmp($sformatf("vec%0d", i), obs(), expv(tbl[i]));
        end

        // Alternation with rd_req held, then urgent back-to-back writes
        do_reset();
        full_seen = 0;
        glog.delete();
        for (int c = 0; c < 30; c++) begin
            pix_valid = (c == 0) || (c >= 2 && c <= 10 && c % 2 == 0);
            pix_data  = 12'h200 + 12'(c);
            rd_req    = (c >= 1);
            rd_addr   = 16'h40;
            tick();
            if (sram_dq_oe && WEb) glog.push_back("W");
            if (rd_gnt)            glog.push_back("R");
            if (fifo_full)         full_seen = 1;
        end
        exp_g = "WRWRWWRWRWR";
        for (int k = 0; k < exp_g.len(); k++) begin
            cmp($sformatf("grant%0d", k), 69'((k < glog.size()) ? glog[k] : 8'h0), 69'(exp_g[k]));
        end
        cmp("alt_full_seen", 69'(full_seen), 69'd1);

        // Six back-to-back pixels with reads pending: one pixel dropped while full
        do_reset();
        full_seen = 0;
        wlog.delete();
        for (int c = 0; c < 40; c++) begin
            pix_valid = (c < 6);
            pix_data  = 12'h101 + 12'(c);
            rd_req    = 1'b1;
            tick();
            if (sram_dq_oe && WEb) wlog.push_back(sram_dq_o[11:0]);
            if (fifo_full)         full_seen = 1;
        end
        rd_req = 1'b0;
        exp_w = '{12'h101, 12'h102, 12'h103, 12'h104, 12'h106};
        cmp("drop_full_seen", 69'(full_seen), 69'd1);
        cmp("drop_write_count", 69'(wlog.size()), 69'd5);
        for (int k = 0; k < 5; k++) begin
            cmp($sformatf("drop_wdata%0d", k), 69'((k < wlog.size()) ? wlog[k] : 12'h0), 69'(exp_w[k]));
        end
`ifdef SRAM_ARB_DROP_CNT_EN
        cmp("drop_cnt", 69'(drop_cnt), 69'd1);
`endif

        // Fill a whole frame and check the wrap
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < 19199; i++) begin
            pix_valid = 1'b1; pix_data = i[11:0];
            tick();
            pix_valid = 1'b0;
            tick();
            if (frame_done) fd_seen++;
        end
        for (int w = 0; w < 20 && wr_addr != 16'd19199; w++) tick();
        cmp("frame_wr_addr_last", 69'(wr_addr), 69'd19199);
        cmp("frame_no_early_done", 69'(fd_seen), 69'd0);
        pix_valid = 1'b1; pix_data = 12'hFED;
        tick();
        pix_valid = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (!WEb) break;
            tick();
        end
        cmp("frame_last_write", 69'({!WEb, sram_addr, sram_dq_o}), 69'({1'b1, 16'd19199, 16'h0FED}));
        tick();
        cmp("frame_wrap", 69'({wr_addr, frame_done}), 69'({16'd0, 1'b1}));
        tick();
        cmp("frame_done_pulse", 69'(frame_done), 69'd0);

        // Frame sync during WR_STROBE with two entries queued
        do_reset();
        pix_valid = 1'b1; pix_data = 12'h0AA;
        tick();
        pix_valid = 1'b0;
        for (int w = 0; w < 5; w++) tick();
        cmp("vs_pre_wr_addr", 69'(wr_addr), 69'd1);
        pix_valid = 1'b1; pix_data = 12'h0A1;
        tick();
        pix_data = 12'h0A2;
        tick();
        pix_data = 12'h0A3;
        tick();
        cmp("vs_strobe_old_addr", 69'({!WEb, sram_addr, sram_dq_o}), 69'({1'b1, 16'd1, 16'h00A1}));
        pix_valid = 1'b0; vsync = 1'b1;
        tick();
        cmp("vs_after_edge", 69'({wr_addr, fifo_full, sram_dq_oe, WEb}), 69'({16'd0, 1'b0, 1'b0, 1'b1}));
        wr_seen = 0;
        for (int w = 0; w < 8; w++) begin
            tick();
            if (sram_dq_oe) wr_seen++;
        end
        cmp("vs_queue_flushed", 69'(wr_seen), 69'd0);
        vsync = 1'b0;
        tick();
        vsync = 1'b1; pix_valid = 1'b1; pix_data = 12'h5A5;
        tick();
        pix_valid = 1'b0;
        for (int w = 0; w < 5; w++) begin
            if (sram_dq_oe) break;
            tick();
        end
        cmp("vs_push_kept", 69'({sram_dq_oe, sram_addr, sram_dq_o}), 69'({1'b1, 16'd0, 16'h05A5}));
        vsync = 1'b0;
        for (int w = 0; w < 4; w++) tick();

        // Reset asserted while a read is in RD_SETUP
        do_reset();
        rd_req = 1'b1; rd_addr = 16'h0030;
        tick();
        cmp("rst_rd_gnt", 69'({rd_gnt, sram_addr}), 69'({1'b1, 16'h0030}));
        res = 1'b1; rd_req = 1'b0;
        tick();
        cmp("rst_mid_read", obs(), reset_obs);
        res = 1'b0;
        vld_seen = 0;
        for (int w = 0; w < 4; w++) begin
            tick();
            if (rd_valid) vld_seen++;
        end
        cmp("rst_no_rd_valid", 69'(vld_seen), 69'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: capture write-queue depth (power of two, 2..16).
REQ-002 Parameter FRAME_WORDS, default 19200: pixel words per frame (160x120); write address wraps here.
REQ-003 pclk  in  1  sole clock, all logic on rising edge.
REQ-004 res  in  1  reset, synchronous, active-high.
REQ-005 vsync  in  1  camera frame sync level; rising edge = new frame.
REQ-006 pix_valid  in  1  one-cycle strobe, pix_data valid.
REQ-007 pix_data  in  12  assembled RGB444 pixel.
REQ-008 rd_req  in  1  readout request, held until rd_gnt.
REQ-009 rd_addr  in  16  readout word address, sampled at grant.
REQ-010 rd_gnt  out  1  one-cycle grant pulse.
REQ-011 rd_valid  out  1  one-cycle strobe, rd_data valid.
REQ-012 rd_data  out  12  read pixel.
REQ-013 sram_addr  out  16  SRAM address.
REQ-014 sram_dq_o  out  16  SRAM write data; sram_dq_oe  out  1  drive enable.
REQ-015 sram_dq_i  in  16  SRAM read data.
REQ-016 WEb, OEb, BLEb, BHEb  out  1 each  active-low SRAM strobes.
REQ-017 wr_addr  out  16  next capture write address.
REQ-018 fifo_full  out  1  queue holds FIFO_DEPTH entries.
REQ-019 frame_done  out  1  one-cycle pulse on write-address wrap.

Function
REQ-020 Queue: pix_valid pushes pix_data; push when full drops pixel, queue unchanged; push and pop same cycle legal, count unchanged.
REQ-021 FSM states IDLE, WR_SETUP, WR_STROBE, RD_SETUP, RD_SAMPLE; each access exactly 2 cycles.
REQ-022 Arbitration evaluated in IDLE, WR_STROBE and RD_SAMPLE; next access begins next cycle with no IDLE gap; nothing pending -> IDLE.
REQ-023 Priority: queue count >= FIFO_DEPTH-1 -> write; else both pending -> alternate, opposite of last granted type; single requester -> that one.
REQ-024 WR_SETUP: sram_addr=wr_addr, sram_dq_o={4'h0,head}, sram_dq_oe=1, WEb=1; WR_STROBE: same, WEb=0; pop and wr_addr increment at end of WR_STROBE.
REQ-025 wr_addr at FRAME_WORDS-1 wraps to 0 with frame_done=1 the following cycle.
REQ-026 rd_gnt=1 in first RD_SETUP cycle, rd_addr latched; RD_SETUP/RD_SAMPLE: OEb=0, sram_dq_oe=0; sram_dq_i[11:0] captured end of RD_SAMPLE; rd_valid=1, rd_data driven next cycle.
REQ-027 Read latency: rd_req in IDLE, no write pending -> rd_gnt next cycle, rd_valid 3 cycles after rd_req.
REQ-028 BLEb=BHEb=0 during any access, else 1; WEb=OEb=1 outside their phases; sram_dq_oe never 1 while OEb=0.
REQ-029 vsync rising edge (registered compare): queue flushed, wr_addr=0 next cycle; in-flight write completes to old address, its increment suppressed; vsync edge and push same cycle -> pixel kept as first of new frame.
REQ-030 rd_data holds last value between rd_valid pulses.

Reset
REQ-031 res sampled each pclk edge; overrides all else, in-flight access aborted.
REQ-032 Reset values: FSM IDLE, queue empty, wr_addr=0, last-grant=read (write wins first tie), rd_gnt=rd_valid=frame_done=fifo_full=0, rd_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, WEb=OEb=BLEb=BHEb=1.

Configuration
REQ-033 Macro SRAM_ARB_DROP_CNT_EN defined: extra output drop_cnt (8 bits) counts dropped pixels, saturates 255, cleared by res and vsync edge; undefined: port and counter absent, behaviour otherwise identical.

Verification
REQ-034 Reset, then 3 pix_valid 0x123,0x456,0x789, no reads -> writes to 0,1,2 with sram_dq_o 0x0123,0x0456,0x0789, wr_addr=3.
REQ-035 rd_req addr 0x0010 in IDLE, sram_dq_i=0xABCD -> rd_gnt at +1, rd_valid at +3, rd_data=0xBCD.
REQ-036 Queue count 1 plus rd_req held, continuous pixels every 2 cycles -> grants alternate W,R,W,R; count 3 -> consecutive writes until count <3.
REQ-037 6 pix_valid back-to-back, rd_req held (FIFO_DEPTH=4) -> fifo_full=1, surplus pixels dropped; with macro drop_cnt = drop count.
REQ-038 wr_addr=19199, one pixel -> write to 19199, wr_addr=0, frame_done one cycle.
REQ-039 vsync rise during WR_STROBE with 2 queued -> write completes to old address, queue empty, wr_addr=0; res mid-RD_SETUP -> all outputs at reset values next cycle, no rd_valid.
